// File: rtl/regfile_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter_pkg
// Shared definitions for the register-file write arbiter slice:
//   - default data / index widths
//   - write-port FSM state encoding (IDLE / WRITE)
//   - index of the hard-wired zero register (writes to it are dropped)
// -----------------------------------------------------------------------------
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEFAULT = 32;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  // Register 0 reads as zero; accepted writes to it never reach the file.
  localparam int unsigned ZERO_REG_IDX = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wrState_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-requester round-robin arbiter with one-hot combinational grants.
// Ports:
//   clk      in   clock
//   rstN     in   async active-low reset (pointer -> requester 0)
//   valid    in   [1:0] request lines (already qualified by the caller)
//   advance  in   a grant was taken this cycle; move the pointer
//   grant    out  [1:0] one-hot grant (all zero when nothing is valid)
// -----------------------------------------------------------------------------
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rstN,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr = index of the requester that wins when both are valid.
  logic ptr;

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  // After a transfer the pointer points at the requester that was not served.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
// Arbitrates two write requesters onto a single register-file write port with
// round-robin priority and a one-cycle registered write path.
// Ports:
//   Clk, Reset_n               clock, async active-low reset
//   Stall                      blocks all acceptance while high
//   ReqNValid/Addr/Data/Ready  requester N handshake (N = 0, 1)
//   RfWriteRegister/Data       registered write index / data
//   RfRegWrite                 registered write enable (never for register 0)
//   ReadRegister1/2            read indices (also go straight to the file)
//   RfReadData1/2              raw read data from the file
//   ReadData1/2                read data to consumers
// Build option: define REGFILE_ARB_BYPASS_EN to forward the pending write
// onto ReadDataN when its index matches ReadRegisterN (nonzero).
// -----------------------------------------------------------------------------
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Stall,
  input  logic              Req0Valid,
  input  logic [ADDR_W-1:0] Req0Addr,
  input  logic [DATA_W-1:0] Req0Data,
  output logic              Req0Ready,
  input  logic              Req1Valid,
  input  logic [ADDR_W-1:0] Req1Addr,
  input  logic [DATA_W-1:0] Req1Data,
  output logic              Req1Ready,
  output logic [ADDR_W-1:0] RfWriteRegister,
  output logic [DATA_W-1:0] RfWriteData,
  output logic              RfRegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  input  logic [DATA_W-1:0] RfReadData1,
  input  logic [DATA_W-1:0] RfReadData2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(ZERO_REG_IDX);

  logic [1:0]        qualValid;
  logic [1:0]        grant;
  logic              transfer;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selData;
  wrState_t          state, stateNext;

  // Reset_n in the qualifier keeps Ready low during reset, so a transfer
  // coinciding with reset assertion can never be taken.
  assign qualValid = {Req1Valid, Req0Valid} & {2{~Stall & Reset_n}};

  rr_arbiter2 uArb (
    .clk     (Clk),
    .rstN    (Reset_n),
    .valid   (qualValid),
    .advance (transfer),
    .grant   (grant)
  );

  assign Req0Ready = grant[0];
  assign Req1Ready = grant[1];
  assign transfer  = |grant;
  assign selAddr   = grant[1] ? Req1Addr : Req0Addr;
  assign selData   = grant[1] ? Req1Data : Req0Data;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = IDLE;
    if (transfer && (selAddr != ZERO_REG)) begin
      stateNext = WRITE;
    end
  end

  // Output logic
  always_comb begin
    RfRegWrite = (state == WRITE);
  end

  // Write index/data hold their last accepted values between transfers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      RfWriteRegister <= '0;
      RfWriteData     <= '0;
    end else if (transfer) begin
      RfWriteRegister <= selAddr;
      RfWriteData     <= selData;
    end
  end

`ifdef REGFILE_ARB_BYPASS_EN
  always_comb begin
    ReadData1 = RfReadData1;
    ReadData2 = RfReadData2;
    if (RfRegWrite && (RfWriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG)) begin
      ReadData1 = RfWriteData;
    end
    if (RfRegWrite && (RfWriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG)) begin
      ReadData2 = RfWriteData;
    end
  end
`else
  assign ReadData1 = RfReadData1;
  assign ReadData2 = RfReadData2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        Reset_n;
  logic        Stall;
  logic        Req0Valid, Req1Valid;
  logic [4:0]  Req0Addr, Req1Addr;
  logic [31:0] Req0Data, Req1Data;
  logic        Req0Ready, Req1Ready;
  logic [4:0]  RfWriteRegister;
  logic [31:0] RfWriteData;
  logic        RfRegWrite;
  logic [4:0]  ReadRegister1, ReadRegister2;
  logic [31:0] RfReadData1, RfReadData2;
  logic [31:0] ReadData1, ReadData2;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who wins next, and what the write port should show.
  int          mPtr;
  logic        mWe;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Stall(Stall),
    .Req0Valid(Req0Valid), .Req0Addr(Req0Addr), .Req0Data(Req0Data), .Req0Ready(Req0Ready),
    .Req1Valid(Req1Valid), .Req1Addr(Req1Addr), .Req1Data(Req1Data), .Req1Ready(Req1Ready),
    .RfWriteRegister(RfWriteRegister), .RfWriteData(RfWriteData), .RfRegWrite(RfRegWrite),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RfReadData1(RfReadData1), .RfReadData2(RfReadData2),
    .ReadData1(ReadData1), .ReadData2(ReadData2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int expGrant();
    if (!Reset_n || Stall) return -1;
    if (Req0Valid && Req1Valid) return mPtr;
    if (Req0Valid) return 0;
    if (Req1Valid) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] rr, input logic [31:0] raw);
`ifdef REGFILE_ARB_BYPASS_EN
    if (mWe && (mAddr == rr) && (rr != 5'd0)) return mData;
`endif
    return raw;
  endfunction

  function automatic void modelReset();
    mPtr  = 0;
    mWe   = 1'b0;
    mAddr = '0;
    mData = '0;
  endfunction

  // One clock: check combinational outputs mid-cycle, then registered ones.
  task automatic runCycle(output int g);
    @(negedge Clk);
    g = expGrant();
    check("req0Ready", 64'(Req0Ready), 64'(g == 0));
    check("req1Ready", 64'(Req1Ready), 64'(g == 1));
    check("readData1", 64'(ReadData1), 64'(expRead(ReadRegister1, RfReadData1)));
    check("readData2", 64'(ReadData2), 64'(expRead(ReadRegister2, RfReadData2)));
    @(posedge Clk);
    #1;
    if (g >= 0) begin
      mPtr  = 1 - g;
      mAddr = (g == 0) ? Req0Addr : Req1Addr;
      mData = (g == 0) ? Req0Data : Req1Data;
      mWe   = (mAddr != 5'd0);
    end else begin
      mWe = 1'b0;
    end
    check("rfRegWrite", 64'(RfRegWrite), 64'(mWe));
    check("rfWriteRegister", 64'(RfWriteRegister), 64'(mAddr));
    check("rfWriteData", 64'(RfWriteData), 64'(mData));
  endtask

  task automatic checkZeroOutputs(input string tag);
    check({tag, "_we"}, 64'(RfRegWrite), 64'(0));
    check({tag, "_addr"}, 64'(RfWriteRegister), 64'(0));
    check({tag, "_data"}, 64'(RfWriteData), 64'(0));
    check({tag, "_rdy0"}, 64'(Req0Ready), 64'(0));
    check({tag, "_rdy1"}, 64'(Req1Ready), 64'(0));
  endtask

  task automatic doReset();
    Reset_n = 1'b0;
    #1;
    checkZeroOutputs("reset");
    @(posedge Clk);
    #1;
    Req0Valid = 1'b0;
    Req1Valid = 1'b0;
    Reset_n   = 1'b1;
    modelReset();
  endtask

  int g;

  initial begin
    Reset_n = 1'b0; Stall = 1'b0;
    Req0Valid = 1'b1; Req0Addr = 5'd3; Req0Data = 32'h1;
    Req1Valid = 1'b1; Req1Addr = 5'd4; Req1Data = 32'h2;
    ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
    RfReadData1 = 32'hA5A5_0001; RfReadData2 = 32'h5A5A_0002;
    modelReset();
    #2;
    doReset();

    // Single requester 0
    Req0Valid = 1'b1; Req0Addr = 5'd16; Req0Data = 32'hDEAD_DAD5;
    runCycle(g);
    Req0Valid = 1'b0;
    runCycle(g);

    // Both valid three cycles after reset: grants alternate 0,1,0
    doReset();
    repeat (3) runCycle(g);
    Req0Valid = 1'b1; Req0Addr = 5'd1; Req0Data = 32'h1111_1111;
    Req1Valid = 1'b1; Req1Addr = 5'd2; Req1Data = 32'h2222_2222;
    repeat (3) runCycle(g);
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    runCycle(g);

    // Write to register 0 is accepted but dropped
    Req1Valid = 1'b1; Req1Addr = 5'd0; Req1Data = 32'hFFFF_FFFF;
    runCycle(g);
    Req1Valid = 1'b0;
    runCycle(g);

    // Stall blocks both; pointer unchanged afterwards
    Stall = 1'b1; Req0Valid = 1'b1; Req1Valid = 1'b1;
    Req0Addr = 5'd7; Req0Data = 32'h7777_0000; Req1Addr = 5'd8; Req1Data = 32'h8888_0000;
    repeat (2) runCycle(g);
    Stall = 1'b0;
    runCycle(g);
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    runCycle(g);

    // Reset asserted during an accepted transfer to register 31
    Req0Valid = 1'b1; Req0Addr = 5'd31; Req0Data = 32'hC0FF_EE31;
    @(negedge Clk);
    check("rstXfer_rdy0_before", 64'(Req0Ready), 64'(1));
    #1;
    Reset_n = 1'b0;
    #1;
    checkZeroOutputs("rstXfer_now");
    @(posedge Clk);
    #1;
    checkZeroOutputs("rstXfer_after");
    modelReset();
    Req0Valid = 1'b0;
    Reset_n = 1'b1;
    runCycle(g);

    // Bypass: read 31 while it is being written
    Req0Valid = 1'b1; Req0Addr = 5'd31; Req0Data = 32'hDEAD_BEEF;
    runCycle(g);
    Req0Valid = 1'b0;
    ReadRegister1 = 5'd31; RfReadData1 = 32'h1234_5678;
    ReadRegister2 = 5'd5;  RfReadData2 = 32'h0BAD_F00D;
    runCycle(g);

    // Randomised traffic; requesters hold until accepted
    for (int i = 0; i < 300; i++) begin
      Stall = ($urandom_range(0, 4) == 0);
      if (!(Req0Valid && g != 0)) begin
        Req0Valid = 1'($urandom_range(0, 1));
        Req0Addr  = 5'($urandom_range(0, 31));
        Req0Data  = $urandom;
      end
      if (!(Req1Valid && g != 1)) begin
        Req1Valid = 1'($urandom_range(0, 1));
        Req1Addr  = 5'($urandom_range(0, 31));
        Req1Data  = $urandom;
      end
      ReadRegister1 = $urandom_range(0, 1) ? mAddr : 5'($urandom_range(0, 31));
      ReadRegister2 = $urandom_range(0, 1) ? mAddr : 5'($urandom_range(0, 31));
      RfReadData1 = $urandom;
      RfReadData2 = $urandom;
      runCycle(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
